trace_readout: RTL



---
 rtl/trace_readout.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/trace_readout.sv
// trace_readout: streams a captured event from four 8-bit sample RAMs, oldest pre-trigger sample first,
// enabled channels 1..4 in order. Define TRACE_READOUT_CHECKSUM_EN to append a per-channel XOR byte.
module trace_readout #(
    parameter int ram_width = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [3:0]           chanmask,
    input  logic [ram_width-1:0] nsmp,
    input  logic [ram_width-1:0] triggerpoint,
    input  logic [ram_width-1:0] wraddress_triggerpoint,
    input  logic                 data_ready,
    output logic                 rden,
    output logic [ram_width-1:0] rdaddress,
    input  logic [7:0]           ram_q1,
    input  logic [7:0]           ram_q2,
    input  logic [7:0]           ram_q3,
    input  logic [7:0]           ram_q4,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [2:0]           dbg_state
);

    // Handshake: once tx_valid rises, tx_data and tx_valid stay stable until a cycle with
    // tx_valid & tx_ready; the byte is transferred on that clock edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAITRDY = 3'd1,
        ADDR    = 3'd2,
        CAPT    = 3'd3,
        SEND    = 3'd4,
`ifdef TRACE_READOUT_CHECKSUM_EN
        CSUM    = 3'd5,
`endif
        NEXTCH  = 3'd6,
        FIN     = 3'd7
    } state_t;

    state_t               state;
    logic [3:0]           mask_q;
    logic [ram_width-1:0] nsmp_q;
    logic [ram_width-1:0] tp_q;
    logic [ram_width-1:0] base_q;
    logic [ram_width-1:0] k;
    logic [1:0]           cur;
    logic                 abort_q;
`ifdef TRACE_READOUT_CHECKSUM_EN
    logic [7:0]           xor_q;
`endif

    logic [ram_width-1:0] base_calc;
    logic [ram_width-1:0] k_next;
    logic [3:0]           mask_rest;
    logic [7:0]           ram_sel;
    logic                 abort_now;
    logic                 last;

    assign base_calc = wraddress_triggerpoint - tp_q;
    assign k_next    = k + ram_width'(1);
    assign mask_rest = mask_q & ~(4'b0001 << cur);
    assign abort_now = abort_q | ~data_ready;
    assign last      = (k_next == nsmp_q);
    assign dbg_state = state;

    always_comb begin
        ram_sel = ram_q1;
        case (cur)
            2'd0: ram_sel = ram_q1;
            2'd1: ram_sel = ram_q2;
            2'd2: ram_sel = ram_q3;
            2'd3: ram_sel = ram_q4;
            default: ram_sel = ram_q1;
        endcase
    end

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            mask_q    <= '0;
            nsmp_q    <= '0;
            tp_q      <= '0;
            base_q    <= '0;
            k         <= '0;
            cur       <= '0;
            abort_q   <= 1'b0;
            rden      <= 1'b0;
            rdaddress <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
`ifdef TRACE_READOUT_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q  <= chanmask;
                        nsmp_q  <= nsmp;
                        tp_q    <= triggerpoint;
                        abort_q <= 1'b0;
                        busy    <= 1'b1;
                        state   <= WAITRDY;
                    end
                end
                WAITRDY: begin
                    if (data_ready) begin
                        if (mask_q == 4'b0000 || nsmp_q == '0) begin
                            state <= FIN;
                        end else begin
                            base_q    <= base_calc;
                            k         <= '0;
                            cur       <= lowest(mask_q);
                            rden      <= 1'b1;
                            rdaddress <= base_calc;
`ifdef TRACE_READOUT_CHECKSUM_EN
                            xor_q     <= '0;
`endif
                            state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    rden <= 1'b0;
                    if (!data_ready) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    if (!data_ready) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tx_data  <= ram_sel;
                        tx_valid <= 1'b1;
`ifdef TRACE_READOUT_CHECKSUM_EN
                        xor_q    <= xor_q ^ ram_sel;
`endif
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!data_ready) abort_q <= 1'b1;
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        k        <= k_next;
                        if (abort_now) begin
                            aborted <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else if (last) begin
`ifdef TRACE_READOUT_CHECKSUM_EN
                            tx_data  <= xor_q;
                            tx_valid <= 1'b1;
                            state    <= CSUM;
`else
                            state    <= NEXTCH;
`endif
                        end else begin
                            rden      <= 1'b1;
                            rdaddress <= base_q + k_next;
                            state     <= ADDR;
                        end
                    end
                end
`ifdef TRACE_READOUT_CHECKSUM_EN
                CSUM: begin
                    if (!data_ready) abort_q <= 1'b1;
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (abort_now) begin
                            aborted <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state <= NEXTCH;
                        end
                    end
                end
`endif
                NEXTCH: begin
                    k <= '0;
                    if (!data_ready) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (mask_rest != 4'b0000) begin
                        mask_q    <= mask_rest;
                        cur       <= lowest(mask_rest);
                        rden      <= 1'b1;
                        rdaddress <= base_q;
`ifdef TRACE_READOUT_CHECKSUM_EN
                        xor_q     <= '0;
`endif
                        state     <= ADDR;
                    end else begin
                        mask_q <= mask_rest;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
